// File: rtl/complete_arbiter.sv
// Completion arbiter: per-FU FIFOs drained by a two-port round-robin onto registered ROB completion buses.
// Optional build macro COMPLETE_ARBITER_STATS_EN adds conflict_cnt_o (cycles with more than two FIFOs pending).
module complete_arbiter #(
    parameter int PC_SIZE    = 32,
    parameter int WORD_SIZE  = 32,
    parameter int NUM_P_REGS = 64,
    parameter int ROB_SIZE   = 16,
    parameter int NUM_REQ    = 3,
    parameter int FIFO_DEPTH = 2,
    localparam int TAG_W     = $clog2(NUM_P_REGS),
    localparam int IDX_W     = $clog2(ROB_SIZE)
) (
    input  logic                                 clk_i,
    input  logic                                 rst_i,
    input  logic [NUM_REQ-1:0]                   req_valid_i,
    output logic [NUM_REQ-1:0]                   req_ready_o,
    input  logic [NUM_REQ-1:0][IDX_W-1:0]        req_rob_index_i,
    input  logic [NUM_REQ-1:0][PC_SIZE-1:0]      req_pc_i,
    input  logic [NUM_REQ-1:0][WORD_SIZE-1:0]    req_val_i,
    input  logic [NUM_REQ-1:0][TAG_W-1:0]        req_dest_i,
    input  logic [NUM_REQ-1:0]                   req_regwrite_i,
    input  logic                                 rob_stall_i,
    output logic [1:0]                           cmp_en_o,
    output logic [1:0][IDX_W-1:0]                cmp_index_o,
    output logic [1:0][PC_SIZE-1:0]              cmp_pc_o,
    output logic [1:0][WORD_SIZE-1:0]            cmp_val_o,
    output logic [1:0][TAG_W-1:0]                cmp_dest_o,
    output logic [1:0]                           cmp_regwrite_o
`ifdef COMPLETE_ARBITER_STATS_EN
    ,
    output logic [31:0]                          conflict_cnt_o
`endif
);
    localparam int ENT_W = IDX_W + PC_SIZE + WORD_SIZE + TAG_W + 1;
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam int RR_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);
    localparam logic [RR_W:0]    NREQ_C  = (RR_W + 1)'(NUM_REQ);

    logic [ENT_W-1:0] mem_q    [NUM_REQ][FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr_q [NUM_REQ];
    logic [PTR_W-1:0] rd_ptr_q [NUM_REQ];
    logic [CNT_W-1:0] count_q  [NUM_REQ];
    logic [RR_W-1:0]  rr_ptr_q, rr_ptr_d;
    logic [NUM_REQ-1:0] push, pop;
    logic [ENT_W-1:0] wr_ent [NUM_REQ];
    logic [1:0]       sel_vld;
    logic [RR_W-1:0]  sel_idx [2];
    logic [ENT_W-1:0] head [2];
    logic [RR_W:0]    cand, rr_nxt;
    logic [RR_W-1:0]  last;

    logic [1:0]                cmp_en_q, cmp_regwrite_q;
    logic [1:0][IDX_W-1:0]     cmp_index_q;
    logic [1:0][PC_SIZE-1:0]   cmp_pc_q;
    logic [1:0][WORD_SIZE-1:0] cmp_val_q;
    logic [1:0][TAG_W-1:0]     cmp_dest_q;

    // Handshake: an entry transfers on a rising edge where valid and ready are both 1;
    // ready depends only on the registered count, so a same-cycle pop never raises it.
    always_comb begin
        for (int r = 0; r < NUM_REQ; r++) begin
            req_ready_o[r] = (count_q[r] < DEPTH_C) && !rst_i;
            push[r]        = req_valid_i[r] && req_ready_o[r];
            wr_ent[r]      = {req_rob_index_i[r], req_pc_i[r], req_val_i[r],
                              req_dest_i[r], req_regwrite_i[r]};
        end
    end

    always_comb begin
        sel_vld    = '0;
        sel_idx[0] = '0;
        sel_idx[1] = '0;
        pop        = '0;
        cand       = '0;
        rr_nxt     = '0;
        last       = '0;
        rr_ptr_d   = rr_ptr_q;
        if (!rob_stall_i) begin
            for (int k = 0; k < NUM_REQ; k++) begin
                cand = {1'b0, rr_ptr_q} + (RR_W + 1)'(k);
                if (cand >= NREQ_C) cand = cand - NREQ_C;
                if (count_q[cand[RR_W-1:0]] != '0) begin
                    if (!sel_vld[0]) begin
                        sel_vld[0] = 1'b1;
                        sel_idx[0] = cand[RR_W-1:0];
                    end else if (!sel_vld[1]) begin
                        sel_vld[1] = 1'b1;
                        sel_idx[1] = cand[RR_W-1:0];
                    end
                end
            end
        end
        for (int p = 0; p < 2; p++) begin
            if (sel_vld[p]) pop[sel_idx[p]] = 1'b1;
        end
        // Pointer moves past whichever requester was granted last this cycle.
        last   = sel_vld[1] ? sel_idx[1] : sel_idx[0];
        rr_nxt = {1'b0, last} + 1'b1;
        if (rr_nxt == NREQ_C) rr_nxt = '0;
        if (sel_vld[0]) rr_ptr_d = rr_nxt[RR_W-1:0];
    end

    assign head[0] = mem_q[sel_idx[0]][rd_ptr_q[sel_idx[0]]];
    assign head[1] = mem_q[sel_idx[1]][rd_ptr_q[sel_idx[1]]];

    always_ff @(posedge clk_i) begin
        for (int r = 0; r < NUM_REQ; r++) begin
            if (push[r]) mem_q[r][wr_ptr_q[r]] <= wr_ent[r];
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int r = 0; r < NUM_REQ; r++) begin
                wr_ptr_q[r] <= '0;
                rd_ptr_q[r] <= '0;
                count_q[r]  <= '0;
            end
            rr_ptr_q       <= '0;
            cmp_en_q       <= '0;
            cmp_index_q    <= '0;
            cmp_pc_q       <= '0;
            cmp_val_q      <= '0;
            cmp_dest_q     <= '0;
            cmp_regwrite_q <= '0;
        end else begin
            for (int r = 0; r < NUM_REQ; r++) begin
                if (push[r]) wr_ptr_q[r] <= wr_ptr_q[r] + 1'b1;
                if (pop[r])  rd_ptr_q[r] <= rd_ptr_q[r] + 1'b1;
                case ({push[r], pop[r]})
                    2'b10:   count_q[r] <= count_q[r] + 1'b1;
                    2'b01:   count_q[r] <= count_q[r] - 1'b1;
                    default: count_q[r] <= count_q[r];
                endcase
            end
            rr_ptr_q <= rr_ptr_d;
            for (int p = 0; p < 2; p++) begin
                cmp_en_q[p] <= sel_vld[p];
                if (sel_vld[p]) begin
                    {cmp_index_q[p], cmp_pc_q[p], cmp_val_q[p],
                     cmp_dest_q[p], cmp_regwrite_q[p]} <= head[p];
                end
            end
        end
    end

    assign cmp_en_o       = cmp_en_q;
    assign cmp_index_o    = cmp_index_q;
    assign cmp_pc_o       = cmp_pc_q;
    assign cmp_val_o      = cmp_val_q;
    assign cmp_dest_o     = cmp_dest_q;
    assign cmp_regwrite_o = cmp_regwrite_q;

`ifdef COMPLETE_ARBITER_STATS_EN
    logic [31:0] conflict_cnt_q;
    logic        conflict;
    int          ne_cnt;

    always_comb begin
        ne_cnt = 0;
        for (int r = 0; r < NUM_REQ; r++) begin
            if (count_q[r] != '0) ne_cnt = ne_cnt + 1;
        end
        conflict = !rob_stall_i && (ne_cnt > 2);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i)                                    conflict_cnt_q <= '0;
        else if (conflict && (conflict_cnt_q != '1))  conflict_cnt_q <= conflict_cnt_q + 1'b1;
    end

    assign conflict_cnt_o = conflict_cnt_q;
`else
    // Statistics build option off: no conflict counter exists.
`endif

endmodule

// File: tb/tb_complete_arbiter.sv
// Directed bench for complete_arbiter: expected completions queued at stimulus time,
// a negedge monitor pops and compares each completion the DUT broadcasts.
module tb_complete_arbiter;
    localparam int EXP_W = 1 + 4 + 32 + 32 + 6 + 1;

    logic             clk;
    logic             rst;
    logic [2:0]       valid;
    logic [2:0]       ready;
    logic [2:0][3:0]  rob_index;
    logic [2:0][31:0] pc;
    logic [2:0][31:0] val;
    logic [2:0][5:0]  dest;
    logic [2:0]       rw;
    logic             stall;
    logic [1:0]       cmp_en;
    logic [1:0][3:0]  cmp_index;
    logic [1:0][31:0] cmp_pc;
    logic [1:0][31:0] cmp_val;
    logic [1:0][5:0]  cmp_dest;
    logic [1:0]       cmp_rw;
`ifdef COMPLETE_ARBITER_STATS_EN
    logic [31:0]      conflict_cnt;
`endif

    logic [EXP_W-1:0] exp_q[$];
    int               checks = 0;
    int               errors = 0;
    logic             mon_on = 1'b1;

    complete_arbiter dut (
        .clk_i           (clk),
        .rst_i           (rst),
        .req_valid_i     (valid),
        .req_ready_o     (ready),
        .req_rob_index_i (rob_index),
        .req_pc_i        (pc),
        .req_val_i       (val),
        .req_dest_i      (dest),
        .req_regwrite_i  (rw),
        .rob_stall_i     (stall),
        .cmp_en_o        (cmp_en),
        .cmp_index_o     (cmp_index),
        .cmp_pc_o        (cmp_pc),
        .cmp_val_o       (cmp_val),
        .cmp_dest_o      (cmp_dest),
        .cmp_regwrite_o  (cmp_rw)
`ifdef COMPLETE_ARBITER_STATS_EN
        ,
        .conflict_cnt_o  (conflict_cnt)
`endif
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // driver tasks
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic at_neg();
        @(negedge clk);
    endtask

    task automatic set_req(input logic [1:0] r, input logic [3:0] i, input logic [31:0] p,
                           input logic [31:0] v, input logic [5:0] d, input logic w);
        valid[r]     = 1'b1;
        rob_index[r] = i;
        pc[r]        = p;
        val[r]       = v;
        dest[r]      = d;
        rw[r]        = w;
    endtask

    task automatic exp_push(input logic pt, input logic [3:0] i, input logic [31:0] p,
                            input logic [31:0] v, input logic [5:0] d, input logic w);
        exp_q.push_back({pt, i, p, v, d, w});
    endtask

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
        end
    endtask

    // scoreboard monitor
    always @(negedge clk) begin
        if (mon_on && !rst) begin
            for (int p = 0; p < 2; p++) begin
                if (cmp_en[p]) begin
                    logic [EXP_W-1:0] act;
                    logic [EXP_W-1:0] exp;
                    logic             pb;
                    pb  = (p == 1);
                    act = {pb, cmp_index[p], cmp_pc[p], cmp_val[p], cmp_dest[p], cmp_rw[p]};
                    checks++;
                    if (exp_q.size() == 0) begin
                        errors++;
                        $display("FAIL unexpected_completion port=%0d actual=%0h expected=none", p, act);
                    end else begin
                        exp = exp_q.pop_front();
                        if (act !== exp) begin
                            errors++;
                            $display("FAIL completion port=%0d actual=%0h expected=%0h", p, act, exp);
                        end
                    end
                end
            end
        end
    end

    initial begin
        rst       = 1'b1;
        stall     = 1'b0;
        valid     = '0;
        rob_index = '0;
        pc        = '0;
        val       = '0;
        dest      = '0;
        rw        = '0;

        // reset state
        step();
        step();
        at_neg();
        chk("reset_ready", 64'(ready), 64'h0);
        chk("reset_cmp_en", 64'(cmp_en), 64'h0);
        chk("reset_cmp_val0", 64'(cmp_val[0]), 64'h0);
        chk("reset_cmp_index1", 64'(cmp_index[1]), 64'h0);
        rst = 1'b0;
        #1;
        chk("post_reset_ready", 64'(ready), 64'h7);

        // single request on ALU0
        set_req(2'd0, 4'd3, 32'h100, 32'h5, 6'd7, 1'b1);
        exp_push(1'b0, 4'd3, 32'h100, 32'h5, 6'd7, 1'b1);
        step();
        valid = '0;
        at_neg();
        chk("no_bypass", 64'(cmp_en), 64'h0);
        step();
        at_neg();
        chk("single_port1_off", 64'(cmp_en[1]), 64'h0);
        step();

        // three simultaneous requests from rr_ptr=0
        rst = 1'b1;
        step();
        rst = 1'b0;
        set_req(2'd0, 4'd1, 32'h200, 32'hA0, 6'd10, 1'b1);
        set_req(2'd1, 4'd2, 32'h204, 32'hA1, 6'd11, 1'b0);
        set_req(2'd2, 4'd4, 32'h208, 32'hA2, 6'd12, 1'b1);
        exp_push(1'b0, 4'd1, 32'h200, 32'hA0, 6'd10, 1'b1);
        exp_push(1'b1, 4'd2, 32'h204, 32'hA1, 6'd11, 1'b0);
        exp_push(1'b0, 4'd4, 32'h208, 32'hA2, 6'd12, 1'b1);
        step();
        valid = '0;
        step();
        step();
        // rr_ptr now 0: ALU0 must take port 0 ahead of MEM0
        set_req(2'd0, 4'd5, 32'h300, 32'hB0, 6'd20, 1'b1);
        set_req(2'd2, 4'd6, 32'h308, 32'hB2, 6'd22, 1'b1);
        exp_push(1'b0, 4'd5, 32'h300, 32'hB0, 6'd20, 1'b1);
        exp_push(1'b1, 4'd6, 32'h308, 32'hB2, 6'd22, 1'b1);
        step();
        valid = '0;
        step();
        step();

        // backpressure on MEM0
        stall = 1'b1;
        set_req(2'd2, 4'd7, 32'h400, 32'hC0, 6'd30, 1'b1);
        step();
        at_neg();
        chk("stall_ready_one_entry", 64'(ready[2]), 64'h1);
        set_req(2'd2, 4'd8, 32'h404, 32'hC1, 6'd31, 1'b0);
        step();
        valid = '0;
        at_neg();
        chk("stall_ready_full", 64'(ready[2]), 64'h0);
        step();
        at_neg();
        chk("stall_no_output", 64'(cmp_en), 64'h0);
        stall = 1'b0;
        exp_push(1'b0, 4'd7, 32'h400, 32'hC0, 6'd30, 1'b1);
        exp_push(1'b0, 4'd8, 32'h404, 32'hC1, 6'd31, 1'b0);
        step();
        step();
        step();

        // full FIFO: pop with a waiting push, then push and pop together
        stall = 1'b1;
        set_req(2'd1, 4'd9, 32'h500, 32'hD0, 6'd40, 1'b1);
        step();
        set_req(2'd1, 4'd10, 32'h504, 32'hD1, 6'd41, 1'b1);
        step();
        at_neg();
        chk("full_ready", 64'(ready[1]), 64'h0);
        stall = 1'b0;
        set_req(2'd1, 4'd11, 32'h508, 32'hD2, 6'd42, 1'b0);
        #1;
        chk("full_ready_no_raise", 64'(ready[1]), 64'h0);
        exp_push(1'b0, 4'd9, 32'h500, 32'hD0, 6'd40, 1'b1);
        exp_push(1'b0, 4'd10, 32'h504, 32'hD1, 6'd41, 1'b1);
        exp_push(1'b0, 4'd11, 32'h508, 32'hD2, 6'd42, 1'b0);
        step();
        at_neg();
        chk("after_pop_ready", 64'(ready[1]), 64'h1);
        step();
        valid = '0;
        at_neg();
        chk("push_pop_ready", 64'(ready[1]), 64'h1);
        step();
        at_neg();
        chk("drained_ready", 64'(ready[1]), 64'h1);
        step();

        // reset with four buffered entries
        stall = 1'b1;
        set_req(2'd0, 4'd12, 32'h600, 32'hE0, 6'd50, 1'b1);
        set_req(2'd1, 4'd13, 32'h604, 32'hE1, 6'd51, 1'b1);
        step();
        step();
        valid = '0;
        stall = 1'b0;
        rst   = 1'b1;
        step();
        at_neg();
        chk("mid_reset_cmp_en", 64'(cmp_en), 64'h0);
        chk("mid_reset_ready", 64'(ready), 64'h0);
        step();
        rst = 1'b0;
        #1;
        chk("after_mid_reset_ready", 64'(ready), 64'h7);
        repeat (4) step();

`ifdef COMPLETE_ARBITER_STATS_EN
        // conflict counter: all three FIFOs non-empty for five unstalled edges
        mon_on = 1'b0;
        stall  = 1'b1;
        set_req(2'd0, 4'd1, 32'h700, 32'hF0, 6'd1, 1'b1);
        set_req(2'd1, 4'd2, 32'h704, 32'hF1, 6'd2, 1'b1);
        set_req(2'd2, 4'd3, 32'h708, 32'hF2, 6'd3, 1'b1);
        step();
        step();
        stall = 1'b0;
        at_neg();
        chk("conflict_start", 64'(conflict_cnt), 64'h0);
        repeat (5) step();
        stall = 1'b1;
        valid = '0;
        at_neg();
        chk("conflict_five", 64'(conflict_cnt), 64'h5);
        rst = 1'b1;
        step();
        rst   = 1'b0;
        stall = 1'b0;
        at_neg();
        chk("conflict_reset", 64'(conflict_cnt), 64'h0);
        mon_on = 1'b1;
`endif

        // bounded drain of the expected queue
        for (int i = 0; i < 20 && exp_q.size() != 0; i++) step();
        chk("exp_q_drained", 64'(exp_q.size()), 64'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
